io_mmio_ctrl: RTL and testbench
===============================

Name: io_mmio_ctrl

Overview:
- Memory-mapped I/O controller between the CPU's data-memory stage and the board I/O: KEY, HEX0/HEX1 and LEDR.
- Decodes the I/O page and sequences one load/store at a time with a valid/ready request and a 1-cycle response pulse.
- Owns the LEDR and HEX registers.
- Debounces KEY, captures press edges into sticky pending flags and raises a key interrupt.

Parameters:
- DBITS, 32, data/address width.
- IO_PAGE, 24'hF00000, value of req_addr[31:8] that selects the I/O page.
- OFF_HEX, 8'h00, offset of the HEX register.
- OFF_LEDR, 8'h04, offset of the LEDR register.
- OFF_KDATA, 8'h10, offset of the debounced key state register (read-only).
- OFF_KCTRL, 8'h14, offset of the key pending/enable register.
- DEBOUNCE_CYC, 1000, number of consecutive stable cycles required before a key change is accepted (>=1).

Ports:
- CLOCK_50  in  1  system clock; all state on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU access request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DBITS  byte address.
- req_wdata  in  DBITS  store data.
- req_ready  out  1  controller can accept a request.
- is_io  out  1  combinational: req_addr[31:8]==IO_PAGE; the CPU routes the access here, not to data memory.
- rsp_valid  out  1  1-cycle completion pulse for loads and stores.
- rsp_rdata  out  DBITS  load data, valid with rsp_valid; 0 for stores.
- KEY  in  4  raw push buttons, active-low, asynchronous.
- HEX0  out  7  low-nibble 7-segment display, active-low, {g,f,e,d,c,b,a}.
- HEX1  out  7  high-nibble 7-segment display, same encoding.
- LEDR  out  10  LED register.
- key_irq  out  1  registered interrupt request.

Behaviour:
- Reset values:
  - hex_reg=0, so HEX0=HEX1=7'h40 (digit 0).
  - LEDR=0, req_ready=1 (after reset deasserts), rsp_valid=0, rsp_rdata=0, key_irq=0.
  - Sync flops, debounce counters, key_stable, pend and ie all 0.
  - FSM returns to IDLE.
- FSM with states IDLE and RESP:
  - IDLE: req_ready=1. Accept when req_valid & is_io. Go to RESP, performing the register write or read capture at that edge.
  - RESP: rsp_valid=1, req_ready=0. Unconditionally return to IDLE.
  - Latency is 1 cycle from accept to rsp_valid. Throughput is 1 access per 2 cycles. The requester holds its request while req_ready=0.
- req_valid with is_io=0 is ignored (no state change, no response).
- Register map (offset = req_addr[7:0]):
  - HEX: write stores wdata[7:0]; read returns {24'b0, hex_reg}. HEX0=seg(hex_reg[3:0]), HEX1=seg(hex_reg[7:4]).
  - LEDR: write stores wdata[9:0]; read returns {22'b0, LEDR}.
  - KDATA: read returns {28'b0, key_stable}; writes ignored.
  - KCTRL: read returns {23'b0, ie, 4'b0, pend}. A write clears pend bits where wdata[3:0]=1 (write-1-to-clear) and sets ie=wdata[8].
  - Unmapped offsets in the page: reads return 0, writes are ignored, and a response is still produced.
- Key path, per bit:
  - 2-flop synchronizer, then inversion to active-high (key_s).
  - If key_s != key_stable, the counter increments; if equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYC, key_stable takes key_s and the counter clears.
  - A stable 0->1 transition sets pend[i].
- Simultaneous pend set and write-1-to-clear on the same bit: the set wins.
- key_irq is registered as ie & |pend, so it follows pend/ie with 1 cycle of delay.
- Reset in RESP: rsp_valid drops on the next edge. A pending write is lost only if the reset edge coincides with the accept edge.

Decomposition:
- Package io_pkg holds:
  - the FSM state enum {IDLE, RESP}
  - default offset constants
  - the 16-entry 7-segment localparam table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Sub-module seg7_decoder (4-bit in, 7-bit out, combinational), instantiated twice.
- Debounce logic stays inline as a generate loop over the 4 keys.

Test Plan:
- Reset -> HEX0=HEX1=7'h40, LEDR=0, key_irq=0, req_ready=1. Read KCTRL -> rsp_rdata=0.
- Store 0x3A to 0xF0000000 -> rsp_valid exactly 1 cycle after accept with req_ready=0 that cycle; HEX1=7'h30, HEX0=7'h08. Load of the same address returns 0x3A.
- Store 0xFFFFFFFF to LEDR -> LEDR=10'h3FF. Store to 0xF0000080 -> response, no state change. Load of the same address -> rsp_rdata=0. Access to 0x00001000 -> is_io=0, no response.
- With DEBOUNCE_CYC=4:
  - KEY[0] low for 3 cycles -> key_stable unchanged.
  - KEY[0] held low -> KDATA=1 after 2+4 cycles and pend[0]=1.
  - With ie=1, key_irq=1 one cycle later.
  - Write KCTRL 0x101 -> pend[0]=0 and key_irq=0.
- Force the pend[1] set on the same edge as a KCTRL write of 0x2 -> pend[1]=1 remains.
- Assert RESET during RESP -> rsp_valid=0 next cycle. All registers return to reset values and req_ready=1 after release.

Source files
------------

// File: rtl/io_mmio_ctrl_pkg.sv
// Shared types and constants for the memory-mapped board I/O controller.
// Holds the access FSM states, default register offsets and the 7-segment table.
package io_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [7:0] OFF_HEX_DEF   = 8'h00;
    localparam logic [7:0] OFF_LEDR_DEF  = 8'h04;
    localparam logic [7:0] OFF_KDATA_DEF = 8'h10;
    localparam logic [7:0] OFF_KCTRL_DEF = 8'h14;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is listed first.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low 7-segment pattern, purely combinational.
module seg7_decoder
    import io_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_LUT[digit_i];

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO controller: one load/store at a time on the I/O page, owns HEX/LEDR,
// debounces KEY into sticky pending flags and drives a registered key interrupt.
module io_mmio_ctrl
    import io_pkg::*;
#(
    parameter int          DBITS        = 32,
    parameter logic [23:0] IO_PAGE      = 24'hF00000,
    parameter logic [7:0]  OFF_HEX      = OFF_HEX_DEF,
    parameter logic [7:0]  OFF_LEDR     = OFF_LEDR_DEF,
    parameter logic [7:0]  OFF_KDATA    = OFF_KDATA_DEF,
    parameter logic [7:0]  OFF_KCTRL    = OFF_KCTRL_DEF,
    parameter int          DEBOUNCE_CYC = 1000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [DBITS-1:0] req_addr,
    input  logic [DBITS-1:0] req_wdata,
    output logic             req_ready,
    output logic             is_io,
    output logic             rsp_valid,
    output logic [DBITS-1:0] rsp_rdata,
    input  logic [3:0]       KEY,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [9:0]       LEDR,
    output logic             key_irq,
    output state_t           dbg_state_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    // Handshake: a request transfers on a rising edge where req_valid, is_io and
    // req_ready are all 1; the requester holds its request while req_ready is 0.
    state_t           state_q, state_d;
    logic             accept;
    logic [7:0]       offset;
    logic [7:0]       hex_q;
    logic [9:0]       ledr_q;
    logic             ie_q;
    logic [3:0]       pend_q, pend_d;
    logic             irq_q;
    logic [DBITS-1:0] rdata_q, rd_data;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       key_s;
    logic [3:0]       key_stable;
    logic [3:0]       key_rise;
    logic             wr_hex, wr_ledr, wr_kctrl;
    logic             unused_wdata;

    assign is_io  = (req_addr[31:8] == IO_PAGE);
    assign offset = req_addr[7:0];
    assign accept = req_ready & req_valid & is_io;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && is_io) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign dbg_state_o = state_q;

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_HEX:   rd_data = DBITS'(hex_q);
            OFF_LEDR:  rd_data = DBITS'(ledr_q);
            OFF_KDATA: rd_data = DBITS'(key_stable);
            OFF_KCTRL: rd_data = DBITS'({ie_q, 4'b0000, pend_q});
            default:   rd_data = '0;
        endcase
    end

    assign wr_hex   = accept & req_we & (offset == OFF_HEX);
    assign wr_ledr  = accept & req_we & (offset == OFF_LEDR);
    assign wr_kctrl = accept & req_we & (offset == OFF_KCTRL);

    // A fresh press on the same edge as a write-1-to-clear keeps the flag set.
    assign pend_d = (pend_q & ~(wr_kctrl ? req_wdata[3:0] : 4'b0000)) | key_rise;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hex_q   <= '0;
            ledr_q  <= '0;
            ie_q    <= 1'b0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            if (wr_hex)   hex_q  <= req_wdata[7:0];
            if (wr_ledr)  ledr_q <= req_wdata[9:0];
            if (wr_kctrl) ie_q   <= req_wdata[8];
            pend_q  <= pend_d;
            irq_q   <= ie_q & (|pend_q);
            rdata_q <= (accept && !req_we) ? rd_data : '0;
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = ~sync2_q;

    for (genvar i = 0; i < 4; i++) begin : g_key
        logic [CW-1:0] cnt_q;
        logic          stable_q;
        logic          fire;

        assign fire = (key_s[i] != stable_q) && (cnt_q == CNT_LAST);

        always_ff @(posedge CLOCK_50) begin
            if (RESET) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else if (key_s[i] == stable_q) begin
                cnt_q <= '0;
            end else if (fire) begin
                cnt_q    <= '0;
                stable_q <= key_s[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign key_stable[i] = stable_q;
        assign key_rise[i]   = fire & key_s[i];
    end

    seg7_decoder u_seg_lo (
        .digit_i (hex_q[3:0]),
        .seg_o   (HEX0)
    );

    seg7_decoder u_seg_hi (
        .digit_i (hex_q[7:4]),
        .seg_o   (HEX1)
    );

    assign LEDR         = ledr_q;
    assign key_irq      = irq_q;
    assign rsp_rdata    = rdata_q;
    assign unused_wdata = ^req_wdata[DBITS-1:10];

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl with a response scoreboard, DEBOUNCE_CYC=4.
module tb_io_mmio_ctrl;
    import io_pkg::*;

    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_KCTRL = 32'hF000_0014;
    localparam logic [31:0] A_HOLE  = 32'hF000_0080;
    localparam logic [31:0] A_MEM   = 32'h0000_1000;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        is_io;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [3:0]  KEY = 4'hF;
    logic [6:0]  HEX0, HEX1;
    logic [9:0]  LEDR;
    logic        key_irq;
    state_t      dbg_state;

    io_mmio_ctrl #(.DEBOUNCE_CYC(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .is_io       (is_io),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .KEY         (KEY),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .LEDR        (LEDR),
        .key_irq     (key_irq),
        .dbg_state_o (dbg_state)
    );

    // Clock/reset block
    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: called at a falling edge; holds the request until it is accepted.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_io);
        int waited;
        waited = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        check("is_io", 32'(is_io), 32'(exp_io));
        if (exp_io) begin
            while (!req_ready && waited < 10) begin
                @(negedge CLOCK_50);
                waited++;
            end
            check("req_ready_wait", 32'(req_ready), 32'd1);
            exp_q.push_back(exp_rd);
            exp_cyc_q.push_back(cyc + 1);
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            req_valid = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(negedge CLOCK_50);
                check("no_rsp_non_io", 32'(rsp_valid), 32'd0);
            end
            req_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
                    check("rsp_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                    check("ready_in_resp", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    task automatic check_reset_state();
        check("hex0_rst", 32'(HEX0), 32'h40);
        check("hex1_rst", 32'(HEX1), 32'h40);
        check("ledr_rst", 32'(LEDR), 32'h0);
        check("irq_rst", 32'(key_irq), 32'h0);
        check("ready_rst", 32'(req_ready), 32'h1);
        check("rsp_valid_rst", 32'(rsp_valid), 32'h0);
        check("rsp_rdata_rst", rsp_rdata, 32'h0);
    endtask

    initial begin
        int drain;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check_reset_state();
        do_access(1'b0, A_KCTRL, 32'h0, 32'h0, 1'b1);

        // HEX and LEDR registers
        do_access(1'b1, A_HEX, 32'h0000_003A, 32'h0, 1'b1);
        check("hex1_3", 32'(HEX1), 32'h30);
        check("hex0_A", 32'(HEX0), 32'h08);
        do_access(1'b0, A_HEX, 32'h0, 32'h3A, 1'b1);
        do_access(1'b1, A_LEDR, 32'hFFFF_FFFF, 32'h0, 1'b1);
        check("ledr_all", 32'(LEDR), 32'h3FF);
        do_access(1'b0, A_LEDR, 32'h0, 32'h3FF, 1'b1);

        // Unmapped offset, non-I/O address, read-only KDATA
        do_access(1'b1, A_HOLE, 32'h1234_5678, 32'h0, 1'b1);
        check("ledr_hole", 32'(LEDR), 32'h3FF);
        check("hex0_hole", 32'(HEX0), 32'h08);
        do_access(1'b0, A_HOLE, 32'h0, 32'h0, 1'b1);
        do_access(1'b1, A_MEM, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_access(1'b0, A_MEM, 32'h0, 32'h0, 1'b0);
        do_access(1'b1, A_KDATA, 32'hF, 32'h0, 1'b1);
        do_access(1'b0, A_KDATA, 32'h0, 32'h0, 1'b1);

        // Short glitch on KEY[0] is rejected
        KEY = 4'hE;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY = 4'hF;
        repeat (6) @(negedge CLOCK_50);
        do_access(1'b0, A_KDATA, 32'h0, 32'h0, 1'b1);
        do_access(1'b0, A_KCTRL, 32'h0, 32'h0, 1'b1);

        // Held press: accepted after 2+4 edges, interrupt one edge later
        do_access(1'b1, A_KCTRL, 32'h100, 32'h0, 1'b1);
        KEY = 4'hE;
        repeat (6) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("irq_not_yet", 32'(key_irq), 32'h0);
        @(negedge CLOCK_50);
        check("irq_set", 32'(key_irq), 32'h1);
        do_access(1'b0, A_KDATA, 32'h0, 32'h1, 1'b1);
        do_access(1'b0, A_KCTRL, 32'h0, 32'h101, 1'b1);
        do_access(1'b1, A_KCTRL, 32'h101, 32'h0, 1'b1);
        @(negedge CLOCK_50);
        check("irq_cleared", 32'(key_irq), 32'h0);
        do_access(1'b0, A_KCTRL, 32'h0, 32'h100, 1'b1);

        // Release produces no pending flag
        KEY = 4'hF;
        repeat (10) @(negedge CLOCK_50);
        do_access(1'b0, A_KDATA, 32'h0, 32'h0, 1'b1);
        do_access(1'b0, A_KCTRL, 32'h0, 32'h100, 1'b1);

        // Press of KEY[1] lands on the same edge as a W1C of bit 1
        KEY = 4'hD;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        do_access(1'b1, A_KCTRL, 32'h2, 32'h0, 1'b1);
        do_access(1'b0, A_KCTRL, 32'h0, 32'h2, 1'b1);
        check("irq_ie_off", 32'(key_irq), 32'h0);
        KEY = 4'hF;
        repeat (10) @(negedge CLOCK_50);

        do_access(1'b1, A_HEX, 32'h5C, 32'h0, 1'b1);
        check("hex1_5", 32'(HEX1), 32'h12);
        check("hex0_C", 32'(HEX0), 32'h46);

        // Reset while the response is being presented
        @(negedge CLOCK_50);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = A_LEDR;
        req_wdata = 32'h155;
        exp_q.push_back(32'h0);
        exp_cyc_q.push_back(cyc + 1);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        req_valid = 1'b0;
        RESET = 1'b1;
        check("ledr_before_rst", 32'(LEDR), 32'h155);
        @(negedge CLOCK_50);
        check("rsp_drop_on_rst", 32'(rsp_valid), 32'h0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check_reset_state();
        do_access(1'b0, A_KCTRL, 32'h0, 32'h0, 1'b1);
        do_access(1'b0, A_HEX, 32'h0, 32'h0, 1'b1);

        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(negedge CLOCK_50);
            drain++;
        end
        check("queue_drain", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
